ppi_bus_ctrl: RTL and testbench
===============================

// Module: ppi_bus_ctrl
// PURPOSE
//  CPU-side bus controller of the 8255 PPI, upstream of the port A/B/C group logic.
//  - Synchronises the asynchronous cs/rd/wr/a0_a1/data bus and commits each write at the end of its cycle.
//  - Owns the control word, the three output latches and the port direction enables.
//  - Decodes mode-set and BSR words; returns port data for CPU reads.
// PARAMETERS
//  SYNC_STAGES  2      flop stages on every bus input (>=2)
//  RESET_CW     8'h9B  control word loaded at reset: mode 0, all ports input
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-low reset
//  cs         in   1  chip select, active-low, async
//  rd         in   1  read strobe, active-low, async
//  wr         in   1  write strobe, active-low, async
//  a0_a1      in   2  register select: 00 PA, 01 PB, 10 PC, 11 control
//  data_in    in   8  CPU data bus, sampled
//  data_out   out  8  CPU read data
//  data_oe    out  1  1 = drive data_out onto the CPU bus
//  pa_in      in   8  port A pins
//  pb_in      in   8  port B pins
//  pc_in      in   8  port C pins
//  pa_out     out  8  port A output latch
//  pb_out     out  8  port B output latch
//  pc_out     out  8  port C output latch
//  pa_oe      out  1  1 = port A drives its pins
//  pb_oe      out  1  1 = port B drives its pins
//  pcu_oe     out  1  1 = PC[7:4] drives its pins
//  pcl_oe     out  1  1 = PC[3:0] drives its pins
//  cw_q       out  8  current control word
//  cw_err     out  1  one-cycle pulse on a rejected mode word
// BEHAVIOUR
//  Reset (reset==0 at clk edge):
//   - cw_q=RESET_CW; pa/pb/pc_out=0; all *_oe=0; data_out=0; cw_err=0.
//   - Sync flops load 1 (strobes inactive); any pending capture is discarded.
//  Sync:
//   - cs, rd, wr, a0_a1 and data_in each pass through SYNC_STAGES flops; the delayed copies are *_s.
//  Write capture:
//   - Each cycle wr_s==0, register {cs_s, a0_a1_s, data_s}; the last sample wins.
//   - Rising edge of wr_s: commit the captured sample if its cs==0, else discard.
//   - Results are visible the cycle after the edge is detected, i.e. SYNC_STAGES+2 clocks after the wr pin rises.
//  Commit decode:
//   - addr 00/01/10: write that output latch with the full byte; direction does not matter, and the value shows once the port turns output.
//   - addr 11, D7=1: mode set.
//     - Accepted only if D6:5==00 and D2==0 (mode 0).
//     - On accept: cw_q<=D; all three output latches clear to 0; pa_oe=~D4, pcu_oe=~D3, pb_oe=~D1, pcl_oe=~D0.
//     - On reject: state unchanged and cw_err pulses one cycle.
//   - addr 11, D7=0: BSR. pc_out[D3:1]<=D0 and every other bit is kept; cw_q is unchanged. BSR acts regardless of pcu_oe/pcl_oe.
//  Read:
//   - data_oe registered = (rd_s==0 && cs_s==0 && a0_a1_s!=11 && wr_s==1), so it rises SYNC_STAGES+1 clocks after the rd pin falls.
//   - data_out is refreshed every cycle while data_oe==1:
//     - PA = pa_oe ? pa_out : pa_in; PB the same with pb_*.
//     - PC: upper nibble from pcu_oe ? pc_out : pc_in, lower nibble from pcl_oe the same way.
//   - data_out holds its last value when data_oe==0.
//   - Control register reads (addr 11) are illegal: data_oe stays 0.
//  Boundaries:
//   - rd_s and wr_s low together: write wins; data_oe is forced 0 and the write commits normally.
//   - A cs change mid-cycle is resolved by the last captured sample only.
//   - wr held low through reset: after release, the sync flops see a fresh falling edge, so the write is captured and commits on its rising edge.
//   - wr released during reset: nothing commits.
//   - Back-to-back writes need at least SYNC_STAGES+1 clocks of wr high between them.
// STRUCTURE
//  Package ppi_pkg:
//   - ADDR_PA/PB/PC/CW (2-bit).
//   - CW bit indices: CW_MODESET=7, CW_GA_MODE=6:5, CW_PA_DIR=4, CW_PCU_DIR=3, CW_GB_MODE=2, CW_PB_DIR=1, CW_PCL_DIR=0.
//   - BSR_SEL=3:1, BSR_VAL=0.
//   - PPI_RESET_CW=8'h9B.
//  Sub-module ppi_sync (WIDTH, SYNC_STAGES, RESET_VAL): a flop chain instantiated once per bus signal group. Everything else is flat in ppi_bus_ctrl.
// TESTING (SYNC_STAGES=2; after each write wait >=4 clks)
//  1. Reset -> cw_q=9B; pa/pb/pc_out=00; all *_oe=0; data_oe=0.
//  2. Write CW 0x80, then PA 0x54 -> pa_oe=pb_oe=pcu_oe=pcl_oe=1; pa_out=54 exactly 4 clks after the wr pin rises.
//  3. PC=00; BSR 0x0F, 0x02, 0x03 -> pc_out 80, 80, 82; cw_q stays 80.
//  4. CW 9B with pa_in=45, read addr 00 -> data_oe=1 on the 3rd clk after rd falls, data_out=45. Then CW 88, PC write 0C, pc_in=A5, read addr 10 -> data_out=AC.
//  5. CW 0xA0 -> cw_err pulses once; cw_q, latches and oe unchanged. Read addr 11 -> data_oe stays 0.
//  6. rd and wr low together at addr 00 with data 33 -> data_oe never rises; pa_out=33. Then reset with wr released while reset is low -> reset values and no commit.

Source files
------------

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared register addresses, control-word fields and helpers for the PPI bus controller
package ppi_pkg;
  localparam logic [1:0] ADDR_PA = 2'b00;
  localparam logic [1:0] ADDR_PB = 2'b01;
  localparam logic [1:0] ADDR_PC = 2'b10;
  localparam logic [1:0] ADDR_CW = 2'b11;
  localparam int CW_MODESET = 7;
  localparam int CW_GA_MODE = 5;
  localparam int CW_PA_DIR  = 4;
  localparam int CW_PCU_DIR = 3;
  localparam int CW_GB_MODE = 2;
  localparam int CW_PB_DIR  = 1;
  localparam int CW_PCL_DIR = 0;
  localparam int BSR_SEL    = 1;
  localparam int BSR_VAL    = 0;
  localparam logic [7:0] PPI_RESET_CW = 8'h9B;
  typedef struct packed {
    logic       cs;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_sample_t;
  function automatic logic mode_ok(input logic [7:0] cw);
    return cw[CW_GA_MODE +: 2] == 2'b00 && !cw[CW_GB_MODE];
  endfunction
endpackage

// File: rtl/ppi_sync.sv
// ppi_sync: multi-stage synchroniser chain for one group of asynchronous bus signals
module ppi_sync #(
  parameter int                 WIDTH       = 1,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [SYNC_STAGES];
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= RESET_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end
  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: 8255 PPI CPU-side bus controller - sync, write commit, mode/BSR decode, port reads
module ppi_bus_ctrl
  import ppi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_CW    = PPI_RESET_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] a0_a1,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic       pa_oe,
  output logic       pb_oe,
  output logic       pcu_oe,
  output logic       pcl_oe,
  output logic [7:0] cw_q,
  output logic       cw_err
);
  logic        cs_s, rd_s, wr_s;
  logic [1:0]  a_s;
  logic [7:0]  d_s;
  logic        wr_d, rise_q, commit, oe_nx;
  bus_sample_t cap;
  logic [7:0]  d, pa_v, pb_v, pc_v, rd_mux;
  ppi_sync #(.WIDTH(3), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(3'b111)) u_strb (
    .clk(clk), .reset(reset), .d({cs, rd, wr}), .q({cs_s, rd_s, wr_s})
  );
  ppi_sync #(.WIDTH(10), .SYNC_STAGES(SYNC_STAGES), .RESET_VAL('1)) u_bus (
    .clk(clk), .reset(reset), .d({a0_a1, data_in}), .q({a_s, d_s})
  );
  assign d      = cap.data;
  assign commit = rise_q && !cap.cs;
  assign oe_nx  = !rd_s && !cs_s && a_s != ADDR_CW && wr_s;
  assign pa_v   = pa_oe ? pa_out : pa_in;
  assign pb_v   = pb_oe ? pb_out : pb_in;
  assign pc_v   = {pcu_oe ? pc_out[7:4] : pc_in[7:4], pcl_oe ? pc_out[3:0] : pc_in[3:0]};
  assign rd_mux = a_s == ADDR_PA ? pa_v : a_s == ADDR_PB ? pb_v : pc_v;
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap      <= '1;
      wr_d     <= 1'b1;
      rise_q   <= 1'b0;
      cw_q     <= RESET_CW;
      pa_out   <= '0;
      pb_out   <= '0;
      pc_out   <= '0;
      pa_oe    <= 1'b0;
      pb_oe    <= 1'b0;
      pcu_oe   <= 1'b0;
      pcl_oe   <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      cw_err   <= 1'b0;
    end else begin
      wr_d    <= wr_s;
      rise_q  <= wr_s && !wr_d;
      if (!wr_s) cap <= '{cs: cs_s, addr: a_s, data: d_s};
      cw_err  <= 1'b0;
      data_oe <= oe_nx;
      if (oe_nx) data_out <= rd_mux;
      if (commit) begin
        if (cap.addr == ADDR_PA) pa_out <= d;
        else if (cap.addr == ADDR_PB) pb_out <= d;
        else if (cap.addr == ADDR_PC) pc_out <= d;
        else if (d[CW_MODESET]) begin
          if (mode_ok(d)) begin
            cw_q   <= d;
            pa_out <= '0;
            pb_out <= '0;
            pc_out <= '0;
            pa_oe  <= !d[CW_PA_DIR];
            pcu_oe <= !d[CW_PCU_DIR];
            pb_oe  <= !d[CW_PB_DIR];
            pcl_oe <= !d[CW_PCL_DIR];
          end else begin
            cw_err <= 1'b1;
          end
        end else begin
          pc_out[d[BSR_SEL +: 3]] <= d[BSR_VAL];
        end
      end
    end
  end
endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// tb_ppi_bus_ctrl: directed self-checking bench for ppi_bus_ctrl with SYNC_STAGES=2
module tb_ppi_bus_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [1:0] a0_a1 = 2'b00;
  logic [7:0] data_in = 8'h00, pa_in = 8'h00, pb_in = 8'h00, pc_in = 8'h00;
  logic [7:0] data_out, pa_out, pb_out, pc_out, cw_q;
  logic       data_oe, pa_oe, pb_oe, pcu_oe, pcl_oe, cw_err;
  int         n_vec = 0, n_bad = 0, err_cnt = 0, oe_seen = 0;
  ppi_bus_ctrl #(.SYNC_STAGES(2), .RESET_CW(8'h9B)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .a0_a1(a0_a1),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
    .pa_oe(pa_oe), .pb_oe(pb_oe), .pcu_oe(pcu_oe), .pcl_oe(pcl_oe),
    .cw_q(cw_q), .cw_err(cw_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      err_cnt += int'(cw_err);
      oe_seen += int'(data_oe);
    end
  endtask
  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    a0_a1 = a; data_in = v; cs = 1'b0; wr = 1'b0;
    tick(3);
    wr = 1'b1; cs = 1'b1;
    tick(6);
  endtask
  task automatic bus_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    @(negedge clk);
    a0_a1 = a; cs = 1'b0; rd = 1'b0;
    tick(2);
    check({tag, "_oe_early"}, {7'b0, data_oe}, 8'h00);
    tick(1);
    check({tag, "_oe"}, {7'b0, data_oe}, 8'h01);
    check({tag, "_data"}, data_out, exp);
    rd = 1'b1; cs = 1'b1;
    tick(5);
  endtask
  initial begin
    tick(4);
    reset = 1'b1;
    tick(2);
    check("rst_cw", cw_q, 8'h9B);
    check("rst_pa", pa_out, 8'h00);
    check("rst_pb", pb_out, 8'h00);
    check("rst_pc", pc_out, 8'h00);
    check("rst_oe", {3'b0, pa_oe, pb_oe, pcu_oe, pcl_oe, data_oe}, 8'h00);
    check("rst_err", {7'b0, cw_err}, 8'h00);
    bus_write(2'b11, 8'h80);
    check("cw80", cw_q, 8'h80);
    check("cw80_oe", {4'b0, pa_oe, pb_oe, pcu_oe, pcl_oe}, 8'h0F);
    @(negedge clk);
    a0_a1 = 2'b00; data_in = 8'h54; cs = 1'b0; wr = 1'b0;
    tick(3);
    wr = 1'b1; cs = 1'b1;
    tick(3);
    check("pa_lat3", pa_out, 8'h00);
    tick(1);
    check("pa_lat4", pa_out, 8'h54);
    tick(4);
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h0F);
    check("bsr_0f", pc_out, 8'h80);
    bus_write(2'b11, 8'h02);
    check("bsr_02", pc_out, 8'h80);
    bus_write(2'b11, 8'h03);
    check("bsr_03", pc_out, 8'h82);
    check("bsr_cw", cw_q, 8'h80);
    bus_write(2'b11, 8'h9B);
    check("cw9b_oe", {4'b0, pa_oe, pb_oe, pcu_oe, pcl_oe}, 8'h00);
    pa_in = 8'h45;
    bus_read("rd_pa", 2'b00, 8'h45);
    bus_write(2'b11, 8'h88);
    bus_write(2'b10, 8'h0C);
    pc_in = 8'hA5;
    bus_read("rd_pc", 2'b10, 8'hAC);
    err_cnt = 0;
    bus_write(2'b11, 8'hA0);
    check("err_cnt", 8'(err_cnt), 8'h01);
    check("err_cw", cw_q, 8'h88);
    check("err_pc", pc_out, 8'h0C);
    check("err_oe", {4'b0, pa_oe, pb_oe, pcu_oe, pcl_oe}, 8'h0D);
    @(negedge clk);
    oe_seen = 0;
    a0_a1 = 2'b11; cs = 1'b0; rd = 1'b0;
    tick(6);
    rd = 1'b1; cs = 1'b1;
    tick(3);
    check("rd_cw_oe", 8'(oe_seen), 8'h00);
    @(negedge clk);
    oe_seen = 0;
    a0_a1 = 2'b00; data_in = 8'h33; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    tick(4);
    rd = 1'b1; wr = 1'b1; cs = 1'b1;
    tick(6);
    check("rdwr_oe", 8'(oe_seen), 8'h00);
    check("rdwr_pa", pa_out, 8'h33);
    @(negedge clk);
    a0_a1 = 2'b00; data_in = 8'h77; cs = 1'b0; wr = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    wr = 1'b1; cs = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(8);
    check("rr_pa", pa_out, 8'h00);
    check("rr_cw", cw_q, 8'h9B);
    check("rr_oe", {3'b0, pa_oe, pb_oe, pcu_oe, pcl_oe, data_oe}, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
